mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory pipeline stage between execute and writeback. Consumes the *_ixmem_p1 bundle from execute,
//  performs loads/stores over a variable-latency req/gnt/rvalid data-memory port, and drives the
//  *_memwb_p1 register-write bundle back into the register file. Stalls execute while an access is in flight.
// PARAMETERS
//  DATA_W     16  data width of register values and memory words
//  ADDR_W     16  data-memory byte address width
//  REG_IDX_W  3   register index width
// PORTS
//  clk                            in   1         clock
//  rst                            in   1         asynchronous, active-low reset
//  dest_reg_value_ixmem_p1        in   DATA_W    ALU result / link value / STU update value
//  dest_reg_index_ixmem_p1        in   REG_IDX_W destination register
//  dest_reg_write_valid_ixmem_p1  in   1         op writes a register
//  mem_addr_ixmem_p1              in   ADDR_W    load/store address
//  ldst_valid_ixmem_p1            in   1         op is a memory access
//  store_valid_ixmem_p1           in   2         00 load, 01 ST, 10 STU, 11 treated as ST
//  mem_data_in_ixmem_p1           in   DATA_W    store data
//  stall_memix_p1                 out  1         execute must hold its outputs this cycle
//  dmem_req_p1 / dmem_we_p1       out  1 / 1     request valid / write
//  dmem_addr_p1 / dmem_wdata_p1   out  ADDR_W / DATA_W  request address / write data
//  dmem_gnt_p1                    in   1         request accepted
//  dmem_rvalid_p1 / dmem_rdata_p1 in   1 / DATA_W  load data return
//  dest_reg_index_memwb_p1        out  REG_IDX_W writeback register
//  dest_reg_value_memwb_p1        out  DATA_W    writeback value
//  dest_reg_write_valid_memwb_p1  out  1         writeback strobe (one cycle per op)
//  err_memwb_p1                   out  1         misaligned-access pulse (MEM_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; dmem_req drops asynchronously; held request regs cleared.
//  - FSM IDLE/REQ/WAIT_RSP. stall_memix_p1 = (state != IDLE), combinational from state.
//  - IDLE accepts the input bundle every cycle. ldst=0 & write_valid=1: memwb regs load it, visible next
//    cycle (latency 1). ldst=0 & write_valid=0: bubble, memwb write_valid=0.
//  - IDLE, ldst=1: capture addr/data/index/value/store type into hold regs -> REQ; memwb write_valid=0.
//  - REQ: dmem_req=1, dmem_we=(store type!=00), addr/wdata from hold regs, stable until gnt.
//    gnt & store: -> IDLE; STU pulses memwb write (held value, held index) next cycle, ST writes nothing.
//    gnt & load: -> WAIT_RSP. No gnt: stay in REQ indefinitely.
//  - WAIT_RSP: dmem_req=0; on rvalid: memwb <= {held index, rdata, 1} -> IDLE. rvalid earliest 1 cycle after gnt.
//  - Latency from accept cycle T (gnt at T+1, rvalid at T+2): store retires T+2, load writeback visible T+3.
//  - gnt outside REQ and rvalid outside WAIT_RSP ignored (covers responses stale after reset mid-access).
//  - dest_reg_write_valid_memwb_p1 is a single-cycle pulse; index/value hold last values when it is 0.
//  - No address arithmetic: addresses pass unmodified; no wrap handling in this block.
// CONFIGURATION
//  MEM_ALIGN_CHECK_EN defined: ldst with mem_addr[0]=1 in IDLE issues no request, stays IDLE, suppresses
//   the register write, and pulses err_memwb_p1 for one cycle (same timing as a writeback).
//  Undefined: address[0] ignored, access issued normally, err_memwb_p1 tied 0.
// STRUCTURE
//  mem_pkg: typedef enum logic [1:0] mem_state_e {MEM_IDLE, MEM_REQ, MEM_WAIT_RSP};
//   localparams ST_LOAD=2'b00, ST_PLAIN=2'b01, ST_UPDATE=2'b10.
//  Sub-module dmem_req_fsm: state register, dmem_req/we, stall; mem_stage keeps hold and memwb regs.
// TESTING
//  1 ALU op value 16'h1234 idx 3 wv=1 -> memwb idx 3 value 16'h1234 wv pulse next cycle, stall stays 0.
//  2 Load addr 16'h0040 idx 5, gnt T+1, rvalid+rdata 16'hBEEF T+2 -> memwb idx 5 16'hBEEF at T+3, stall T+1..T+2.
//  3 ST addr 16'h0010 data 16'h00AA, gnt delayed to T+4 -> req/addr/wdata stable T+1..T+4, no writeback, IDLE T+5.
//  4 STU addr 16'h0020 value 16'h0020 idx 2, gnt T+1 -> dmem_we=1, memwb idx 2 16'h0020 at T+2.
//  5 rst low during WAIT_RSP, late rvalid 16'h5555 after release -> no writeback, outputs 0, stall 0.
//  6 MEM_ALIGN_CHECK_EN: load addr 16'h0041 -> no dmem_req, err pulse next cycle, wv 0; undefined: req addr 16'h0041.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory pipeline stage: FSM state encoding and store-type codes.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE     = 2'd0,
        MEM_REQ      = 2'd1,
        MEM_WAIT_RSP = 2'd2
    } mem_state_e;

    localparam logic [1:0] ST_LOAD   = 2'b00;
    localparam logic [1:0] ST_PLAIN  = 2'b01;
    localparam logic [1:0] ST_UPDATE = 2'b10;

    // 2'b11 is not a distinct op; it behaves as a plain store.
    function automatic logic is_store(input logic [1:0] st_type);
        return st_type != ST_LOAD;
    endfunction

    function automatic logic is_update(input logic [1:0] st_type);
        return st_type == ST_UPDATE;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response port: req/gnt handshake with a separate rvalid load return.
interface mem_stage_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              dmem_req_p1;
    logic              dmem_we_p1;
    logic [ADDR_W-1:0] dmem_addr_p1;
    logic [DATA_W-1:0] dmem_wdata_p1;
    logic              dmem_gnt_p1;
    logic              dmem_rvalid_p1;
    logic [DATA_W-1:0] dmem_rdata_p1;

    modport master (
        output dmem_req_p1, dmem_we_p1, dmem_addr_p1, dmem_wdata_p1,
        input  dmem_gnt_p1, dmem_rvalid_p1, dmem_rdata_p1
    );

    modport slave (
        input  dmem_req_p1, dmem_we_p1, dmem_addr_p1, dmem_wdata_p1,
        output dmem_gnt_p1, dmem_rvalid_p1, dmem_rdata_p1
    );
endinterface

// File: rtl/mem_stage_dmem_req_fsm.sv
// Request sequencer for the data-memory port: tracks IDLE/REQ/WAIT_RSP, drives req/we and stall.
module dmem_req_fsm
    import mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start_p1,
    input  logic start_store_p1,
    input  logic gnt_p1,
    input  logic rvalid_p1,
    output logic req_p1,
    output logic we_p1,
    output logic stall_p1,
    output logic store_done_p1,
    output logic load_done_p1
);

    mem_state_e state_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p1 <= MEM_IDLE;
            req_p1   <= 1'b0;
            we_p1    <= 1'b0;
        end else begin
            case (state_p1)
                MEM_IDLE: begin
                    if (start_p1) begin
                        state_p1 <= MEM_REQ;
                        req_p1   <= 1'b1;
                        we_p1    <= start_store_p1;
                    end
                end
                MEM_REQ: begin
                    // Request holds until granted; there is no timeout.
                    if (gnt_p1) begin
                        state_p1 <= we_p1 ? MEM_IDLE : MEM_WAIT_RSP;
                        req_p1   <= 1'b0;
                        we_p1    <= 1'b0;
                    end
                end
                MEM_WAIT_RSP: begin
                    if (rvalid_p1) begin
                        state_p1 <= MEM_IDLE;
                    end
                end
                default: begin
                    state_p1 <= MEM_IDLE;
                    req_p1   <= 1'b0;
                    we_p1    <= 1'b0;
                end
            endcase
        end
    end

    // gnt/rvalid only count in their own state, so stale responses after a reset are dropped.
    assign stall_p1      = (state_p1 != MEM_IDLE);
    assign store_done_p1 = (state_p1 == MEM_REQ) && gnt_p1 && we_p1;
    assign load_done_p1  = (state_p1 == MEM_WAIT_RSP) && rvalid_p1;

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage between execute and writeback; issues loads/stores and produces writebacks.
// Optional MEM_ALIGN_CHECK_EN: reject odd-address accesses with an err_memwb_p1 pulse.
module mem_stage
    import mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int REG_IDX_W = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_W-1:0]    dest_reg_value_ixmem_p1,
    input  logic [REG_IDX_W-1:0] dest_reg_index_ixmem_p1,
    input  logic                 dest_reg_write_valid_ixmem_p1,
    input  logic [ADDR_W-1:0]    mem_addr_ixmem_p1,
    input  logic                 ldst_valid_ixmem_p1,
    input  logic [1:0]           store_valid_ixmem_p1,
    input  logic [DATA_W-1:0]    mem_data_in_ixmem_p1,
    output logic                 stall_memix_p1,
    mem_stage_if.master          dmem,
    output logic [REG_IDX_W-1:0] dest_reg_index_memwb_p1,
    output logic [DATA_W-1:0]    dest_reg_value_memwb_p1,
    output logic                 dest_reg_write_valid_memwb_p1,
    output logic                 err_memwb_p1
);

    logic                 accept_p1;
    logic                 misalign_p1;
    logic                 start_p1;
    logic                 store_done_p1;
    logic                 load_done_p1;
    logic [ADDR_W-1:0]    hold_addr_p1;
    logic [DATA_W-1:0]    hold_wdata_p1;
    logic [DATA_W-1:0]    hold_value_p1;
    logic [REG_IDX_W-1:0] hold_index_p1;
    logic [1:0]           hold_type_p1;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign_p1 = ldst_valid_ixmem_p1 && mem_addr_ixmem_p1[0];
`else
    assign misalign_p1 = 1'b0;
`endif

    assign accept_p1 = !stall_memix_p1;
    assign start_p1  = accept_p1 && ldst_valid_ixmem_p1 && !misalign_p1;

    dmem_req_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .start_p1       (start_p1),
        .start_store_p1 (is_store(store_valid_ixmem_p1)),
        .gnt_p1         (dmem.dmem_gnt_p1),
        .rvalid_p1      (dmem.dmem_rvalid_p1),
        .req_p1         (dmem.dmem_req_p1),
        .we_p1          (dmem.dmem_we_p1),
        .stall_p1       (stall_memix_p1),
        .store_done_p1  (store_done_p1),
        .load_done_p1   (load_done_p1)
    );

    assign dmem.dmem_addr_p1  = hold_addr_p1;
    assign dmem.dmem_wdata_p1 = hold_wdata_p1;

    // ---- accept boundary: capture the access so execute can move on ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_addr_p1  <= '0;
            hold_wdata_p1 <= '0;
            hold_value_p1 <= '0;
            hold_index_p1 <= '0;
            hold_type_p1  <= ST_LOAD;
        end else if (start_p1) begin
            hold_addr_p1  <= mem_addr_ixmem_p1;
            hold_wdata_p1 <= mem_data_in_ixmem_p1;
            hold_value_p1 <= dest_reg_value_ixmem_p1;
            hold_index_p1 <= dest_reg_index_ixmem_p1;
            hold_type_p1  <= store_valid_ixmem_p1;
        end
    end

    // ---- writeback boundary: strobe pulses one cycle, index/value hold ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dest_reg_index_memwb_p1       <= '0;
            dest_reg_value_memwb_p1       <= '0;
            dest_reg_write_valid_memwb_p1 <= 1'b0;
            err_memwb_p1                  <= 1'b0;
        end else begin
            dest_reg_write_valid_memwb_p1 <= 1'b0;
            err_memwb_p1                  <= 1'b0;
            if (accept_p1) begin
                if (misalign_p1) begin
                    err_memwb_p1 <= 1'b1;
                end else if (!ldst_valid_ixmem_p1 && dest_reg_write_valid_ixmem_p1) begin
                    dest_reg_index_memwb_p1       <= dest_reg_index_ixmem_p1;
                    dest_reg_value_memwb_p1       <= dest_reg_value_ixmem_p1;
                    dest_reg_write_valid_memwb_p1 <= 1'b1;
                end
            end
            if (store_done_p1 && is_update(hold_type_p1)) begin
                dest_reg_index_memwb_p1       <= hold_index_p1;
                dest_reg_value_memwb_p1       <= hold_value_p1;
                dest_reg_write_valid_memwb_p1 <= 1'b1;
            end
            if (load_done_p1) begin
                dest_reg_index_memwb_p1       <= hold_index_p1;
                dest_reg_value_memwb_p1       <= dmem.dmem_rdata_p1;
                dest_reg_write_valid_memwb_p1 <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU vector table plus load/store/STU/reset/alignment sequences.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic [15:0] value_in;
    logic [2:0]  index_in;
    logic        wv_in;
    logic [15:0] addr_in;
    logic        ldst_in;
    logic [1:0]  st_in;
    logic [15:0] data_in;
    logic        stall;
    logic [2:0]  wb_index;
    logic [15:0] wb_value;
    logic        wb_wv;
    logic        err;

    int total = 0;
    int bad   = 0;

    mem_stage_if #(.ADDR_W(16), .DATA_W(16)) dmem ();

    mem_stage #(.DATA_W(16), .ADDR_W(16), .REG_IDX_W(3)) dut (
        .clk                           (clk),
        .rst                           (rst),
        .dest_reg_value_ixmem_p1       (value_in),
        .dest_reg_index_ixmem_p1       (index_in),
        .dest_reg_write_valid_ixmem_p1 (wv_in),
        .mem_addr_ixmem_p1             (addr_in),
        .ldst_valid_ixmem_p1           (ldst_in),
        .store_valid_ixmem_p1          (st_in),
        .mem_data_in_ixmem_p1          (data_in),
        .stall_memix_p1                (stall),
        .dmem                          (dmem.master),
        .dest_reg_index_memwb_p1       (wb_index),
        .dest_reg_value_memwb_p1       (wb_value),
        .dest_reg_write_valid_memwb_p1 (wb_wv),
        .err_memwb_p1                  (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] value;
        logic [2:0]  index;
        logic        wv;
        logic        exp_wv;
        logic [2:0]  exp_index;
        logic [15:0] exp_value;
    } alu_vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] v, input logic [2:0] i, input logic w,
                         input logic [15:0] a, input logic l, input logic [1:0] s,
                         input logic [15:0] d);
        value_in = v; index_in = i; wv_in = w;
        addr_in = a; ldst_in = l; st_in = s; data_in = d;
    endtask

    task automatic bubble();
        drive(16'h0, 3'd0, 1'b0, 16'h0, 1'b0, 2'b00, 16'h0);
    endtask

    alu_vec_t vecs[6];

    initial begin
        vecs[0] = '{16'h1234, 3'd3, 1'b1, 1'b1, 3'd3, 16'h1234};
        vecs[1] = '{16'h00FF, 3'd7, 1'b1, 1'b1, 3'd7, 16'h00FF};
        vecs[2] = '{16'hDEAD, 3'd1, 1'b0, 1'b0, 3'd7, 16'h00FF};
        vecs[3] = '{16'h0000, 3'd0, 1'b1, 1'b1, 3'd0, 16'h0000};
        vecs[4] = '{16'hFFFF, 3'd6, 1'b1, 1'b1, 3'd6, 16'hFFFF};
        vecs[5] = '{16'h8000, 3'd2, 1'b0, 1'b0, 3'd6, 16'hFFFF};

        rst = 1'b0;
        bubble();
        dmem.dmem_gnt_p1    = 1'b0;
        dmem.dmem_rvalid_p1 = 1'b0;
        dmem.dmem_rdata_p1  = 16'h0;
        #12;
        check("reset_stall", stall, 0);
        check("reset_req", dmem.dmem_req_p1, 0);
        check("reset_wv", wb_wv, 0);
        check("reset_value", wb_value, 0);
        check("reset_err", err, 0);
        step();
        rst = 1'b1;
        step();

        // ALU pass-through, back to back
        for (int k = 0; k < 6; k++) begin
            drive(vecs[k].value, vecs[k].index, vecs[k].wv, 16'h0, 1'b0, 2'b00, 16'h0);
            step();
            check($sformatf("alu%0d_wv", k), wb_wv, vecs[k].exp_wv);
            check($sformatf("alu%0d_idx", k), wb_index, vecs[k].exp_index);
            check($sformatf("alu%0d_val", k), wb_value, vecs[k].exp_value);
            check($sformatf("alu%0d_stall", k), stall, 0);
            check($sformatf("alu%0d_req", k), dmem.dmem_req_p1, 0);
        end
        bubble();
        step();
        check("alu_pulse_end", wb_wv, 0);

        // Load: gnt T+1, rvalid T+2, writeback T+3
        drive(16'h0, 3'd5, 1'b0, 16'h0040, 1'b1, 2'b00, 16'h0);
        step();
        bubble();
        check("ld_req", dmem.dmem_req_p1, 1);
        check("ld_we", dmem.dmem_we_p1, 0);
        check("ld_addr", dmem.dmem_addr_p1, 16'h0040);
        check("ld_stall_t1", stall, 1);
        check("ld_wv_t1", wb_wv, 0);
        dmem.dmem_gnt_p1 = 1'b1;
        step();
        dmem.dmem_gnt_p1 = 1'b0;
        check("ld_req_t2", dmem.dmem_req_p1, 0);
        check("ld_stall_t2", stall, 1);
        dmem.dmem_rvalid_p1 = 1'b1;
        dmem.dmem_rdata_p1  = 16'hBEEF;
        step();
        dmem.dmem_rvalid_p1 = 1'b0;
        check("ld_wv_t3", wb_wv, 1);
        check("ld_idx_t3", wb_index, 3'd5);
        check("ld_val_t3", wb_value, 16'hBEEF);
        check("ld_stall_t3", stall, 0);
        step();
        check("ld_wv_t4", wb_wv, 0);
        check("ld_val_hold", wb_value, 16'hBEEF);

        // Plain store with grant delayed to T+4
        drive(16'h7777, 3'd4, 1'b0, 16'h0010, 1'b1, 2'b01, 16'h00AA);
        step();
        bubble();
        for (int k = 1; k <= 4; k++) begin
            check($sformatf("st_req_t%0d", k), dmem.dmem_req_p1, 1);
            check($sformatf("st_we_t%0d", k), dmem.dmem_we_p1, 1);
            check($sformatf("st_addr_t%0d", k), dmem.dmem_addr_p1, 16'h0010);
            check($sformatf("st_wdata_t%0d", k), dmem.dmem_wdata_p1, 16'h00AA);
            check($sformatf("st_stall_t%0d", k), stall, 1);
            if (k == 4) dmem.dmem_gnt_p1 = 1'b1;
            step();
        end
        dmem.dmem_gnt_p1 = 1'b0;
        check("st_req_t5", dmem.dmem_req_p1, 0);
        check("st_stall_t5", stall, 0);
        check("st_wv_t5", wb_wv, 0);
        check("st_val_t5", wb_value, 16'hBEEF);

        // Store-with-update: grant T+1, writeback T+2
        drive(16'h0020, 3'd2, 1'b0, 16'h0020, 1'b1, 2'b10, 16'h1111);
        step();
        bubble();
        check("stu_req", dmem.dmem_req_p1, 1);
        check("stu_we", dmem.dmem_we_p1, 1);
        check("stu_wdata", dmem.dmem_wdata_p1, 16'h1111);
        dmem.dmem_gnt_p1 = 1'b1;
        step();
        dmem.dmem_gnt_p1 = 1'b0;
        check("stu_wv_t2", wb_wv, 1);
        check("stu_idx_t2", wb_index, 3'd2);
        check("stu_val_t2", wb_value, 16'h0020);
        check("stu_stall_t2", stall, 0);
        step();
        check("stu_wv_t3", wb_wv, 0);

        // Reset during WAIT_RSP, then a stale rvalid
        drive(16'h0, 3'd4, 1'b0, 16'h0050, 1'b1, 2'b00, 16'h0);
        step();
        bubble();
        dmem.dmem_gnt_p1 = 1'b1;
        step();
        dmem.dmem_gnt_p1 = 1'b0;
        check("rst_wait_stall", stall, 1);
        #1 rst = 1'b0;
        #1;
        check("rst_async_stall", stall, 0);
        check("rst_async_req", dmem.dmem_req_p1, 0);
        check("rst_async_val", wb_value, 0);
        check("rst_async_idx", wb_index, 0);
        step();
        rst = 1'b1;
        dmem.dmem_rvalid_p1 = 1'b1;
        dmem.dmem_rdata_p1  = 16'h5555;
        step();
        dmem.dmem_rvalid_p1 = 1'b0;
        check("stale_wv", wb_wv, 0);
        check("stale_val", wb_value, 0);
        check("stale_stall", stall, 0);
        dmem.dmem_gnt_p1 = 1'b1;
        step();
        dmem.dmem_gnt_p1 = 1'b0;
        check("stale_gnt_req", dmem.dmem_req_p1, 0);
        check("stale_gnt_stall", stall, 0);

        // Reset while REQ is outstanding drops the request immediately
        drive(16'h0, 3'd1, 1'b0, 16'h0060, 1'b1, 2'b00, 16'h0);
        step();
        bubble();
        check("rstreq_req_before", dmem.dmem_req_p1, 1);
        #2 rst = 1'b0;
        #1;
        check("rstreq_req_after", dmem.dmem_req_p1, 0);
        step();
        rst = 1'b1;
        step();
        check("rstreq_stall", stall, 0);

        // Odd-address load
        drive(16'h0, 3'd5, 1'b0, 16'h0041, 1'b1, 2'b00, 16'h0);
        step();
        bubble();
`ifdef MEM_ALIGN_CHECK_EN
        check("align_req", dmem.dmem_req_p1, 0);
        check("align_stall", stall, 0);
        check("align_err", err, 1);
        check("align_wv", wb_wv, 0);
        step();
        check("align_err_end", err, 0);
`else
        check("noalign_req", dmem.dmem_req_p1, 1);
        check("noalign_addr", dmem.dmem_addr_p1, 16'h0041);
        check("noalign_err", err, 0);
        dmem.dmem_gnt_p1 = 1'b1;
        step();
        dmem.dmem_gnt_p1 = 1'b0;
        dmem.dmem_rvalid_p1 = 1'b1;
        dmem.dmem_rdata_p1  = 16'hC0DE;
        step();
        dmem.dmem_rvalid_p1 = 1'b0;
        check("noalign_wv", wb_wv, 1);
        check("noalign_val", wb_value, 16'hC0DE);
        check("noalign_err_wb", err, 0);
`endif
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
